// File: rtl/seq_detector_param.sv
// Serial sequence detector: flags when the last PAT_LEN enabled samples equal PAT_A or PAT_B.
// Supports overlap/non-overlap matching, fill/history debug outputs and a saturating match counter.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PAT_A   = 4'b1111,
  parameter logic [PAT_LEN-1:0] PAT_B   = 4'b1101,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       w,
  input  logic                       count_clr,
  output logic                       match_a,
  output logic                       match_b,
  output logic                       match,
  output logic [$clog2(PAT_LEN+1)-1:0] fill,
  output logic [PAT_LEN-1:0]         history,
  output logic [CNT_W-1:0]           match_count
);

  localparam int FILL_W = $clog2(PAT_LEN+1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] history_q, history_d, hist_n;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_n;
  logic               match_a_q, match_a_d;
  logic               match_b_q, match_b_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               hit_a, hit_b;

  always_comb begin
    hist_n    = {history_q[PAT_LEN-2:0], w};
    fill_n    = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    hit_a     = (fill_n == FULL) && (hist_n == PAT_A);
    hit_b     = (fill_n == FULL) && (hist_n == PAT_B);

    history_d = history_q;
    fill_d    = fill_q;
    match_a_d = match_a_q;
    match_b_d = match_b_q;
    count_d   = count_q;

    if (enable) begin
      history_d = hist_n;
      match_a_d = hit_a;
      match_b_d = hit_b;
      // Non-overlap mode restarts the fill so the next match needs PAT_LEN fresh bits.
      if (!OVERLAP && (hit_a || hit_b))
        fill_d = '0;
      else
        fill_d = fill_n;
    end

    if (count_clr)
      count_d = '0;
    else if (enable && (hit_a || hit_b) && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      history_q <= '0;
      fill_q    <= '0;
      match_a_q <= 1'b0;
      match_b_q <= 1'b0;
      count_q   <= '0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
      match_a_q <= match_a_d;
      match_b_q <= match_b_d;
      count_q   <= count_d;
    end
  end

  assign match_a     = match_a_q;
  assign match_b     = match_b_q;
  assign match       = match_a_q | match_b_q;
  assign fill        = fill_q;
  assign history     = history_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: four parameter variants share one input stream and are
// compared every cycle against a sample-list reference model.
module tb_seq_detector_param;

  localparam int NDUT = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b1;
  logic enable = 1'b0;
  logic w = 1'b0;
  logic count_clr = 1'b0;

  logic       d0_ma, d0_mb, d0_m; logic [2:0] d0_fill; logic [3:0] d0_hist; logic [7:0] d0_cnt;
  logic       d1_ma, d1_mb, d1_m; logic [2:0] d1_fill; logic [3:0] d1_hist; logic [7:0] d1_cnt;
  logic       d2_ma, d2_mb, d2_m; logic [2:0] d2_fill; logic [3:0] d2_hist; logic [1:0] d2_cnt;
  logic       d3_ma, d3_mb, d3_m; logic [1:0] d3_fill; logic [2:0] d3_hist; logic [3:0] d3_cnt;

  seq_detector_param #(.PAT_LEN(4), .PAT_A(4'b1111), .PAT_B(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .count_clr(count_clr),
    .match_a(d0_ma), .match_b(d0_mb), .match(d0_m), .fill(d0_fill), .history(d0_hist), .match_count(d0_cnt));

  seq_detector_param #(.PAT_LEN(4), .PAT_A(4'b1111), .PAT_B(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .count_clr(count_clr),
    .match_a(d1_ma), .match_b(d1_mb), .match(d1_m), .fill(d1_fill), .history(d1_hist), .match_count(d1_cnt));

  seq_detector_param #(.PAT_LEN(4), .PAT_A(4'b1111), .PAT_B(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .count_clr(count_clr),
    .match_a(d2_ma), .match_b(d2_mb), .match(d2_m), .fill(d2_fill), .history(d2_hist), .match_count(d2_cnt));

  seq_detector_param #(.PAT_LEN(3), .PAT_A(3'b000), .PAT_B(3'b101), .OVERLAP(1'b0), .CNT_W(4)) dut3 (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .count_clr(count_clr),
    .match_a(d3_ma), .match_b(d3_mb), .match(d3_m), .fill(d3_fill), .history(d3_hist), .match_count(d3_cnt));

  int plen  [NDUT] = '{4, 4, 4, 3};
  int pat_a [NDUT] = '{15, 15, 15, 0};
  int pat_b [NDUT] = '{13, 13, 15, 5};
  bit ovl   [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int cmax  [NDUT] = '{255, 255, 3, 15};

  typedef struct packed {
    logic [NDUT-1:0]       ma;
    logic [NDUT-1:0]       mb;
    logic [NDUT-1:0][7:0]  fill;
    logic [NDUT-1:0][15:0] hist;
    logic [NDUT-1:0][7:0]  cnt;
  } exp_t;

  exp_t sb[$];

  bit samples[$];
  int since_flush [NDUT];
  bit m_a [NDUT];
  bit m_b [NDUT];
  int m_cnt [NDUT];

  int total = 0;
  int bad = 0;

  // History is simply the newest L samples since reset, newest in bit 0, zeros where none exist yet.
  function automatic int hist_val(input int len);
    int v = 0;
    for (int k = 0; k < len; k++)
      if (k < samples.size())
        v = v | (int'(samples[samples.size()-1-k]) << k);
    return v;
  endfunction

  task automatic checkOutput(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL dut%0d %s got=%0h want=%0h at %0t", idx, nm, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit wb, input bit clr);
    exp_t e;
    int h;
    bit ha, hb;
    @(negedge clock);
    reset = rst; enable = en; w = wb; count_clr = clr;
    if (rst) begin
      samples.delete();
      for (int i = 0; i < NDUT; i++) begin
        since_flush[i] = 0; m_a[i] = 1'b0; m_b[i] = 1'b0; m_cnt[i] = 0;
      end
    end else begin
      if (en) begin
        samples.push_back(wb);
        if (samples.size() > 16) void'(samples.pop_front());
      end
      for (int i = 0; i < NDUT; i++) begin
        ha = 1'b0; hb = 1'b0;
        if (en) begin
          since_flush[i]++;
          h  = hist_val(plen[i]);
          ha = (since_flush[i] >= plen[i]) && (h == pat_a[i]);
          hb = (since_flush[i] >= plen[i]) && (h == pat_b[i]);
          m_a[i] = ha;
          m_b[i] = hb;
          if ((ha || hb) && !ovl[i]) since_flush[i] = 0;
        end
        if (clr) m_cnt[i] = 0;
        else if (en && (ha || hb) && m_cnt[i] < cmax[i]) m_cnt[i]++;
      end
    end
    for (int i = 0; i < NDUT; i++) begin
      e.ma[i]   = m_a[i];
      e.mb[i]   = m_b[i];
      e.fill[i] = 8'((since_flush[i] < plen[i]) ? since_flush[i] : plen[i]);
      e.hist[i] = 16'(hist_val(plen[i]));
      e.cnt[i]  = 8'(m_cnt[i]);
    end
    sb.push_back(e);
  endtask

  // Monitor: every cycle the DUTs present registered state; pop one expectation and compare.
  initial begin
    exp_t e;
    logic [NDUT-1:0] ama, amb, am;
    logic [NDUT-1:0][7:0] afill, acnt;
    logic [NDUT-1:0][15:0] ahist;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        ama = {d3_ma, d2_ma, d1_ma, d0_ma};
        amb = {d3_mb, d2_mb, d1_mb, d0_mb};
        am  = {d3_m, d2_m, d1_m, d0_m};
        afill[0] = 8'(d0_fill); afill[1] = 8'(d1_fill); afill[2] = 8'(d2_fill); afill[3] = 8'(d3_fill);
        ahist[0] = 16'(d0_hist); ahist[1] = 16'(d1_hist); ahist[2] = 16'(d2_hist); ahist[3] = 16'(d3_hist);
        acnt[0]  = 8'(d0_cnt); acnt[1] = 8'(d1_cnt); acnt[2] = 8'(d2_cnt); acnt[3] = 8'(d3_cnt);
        for (int i = 0; i < NDUT; i++) begin
          checkOutput("match_a", i, 32'(ama[i]), 32'(e.ma[i]));
          checkOutput("match_b", i, 32'(amb[i]), 32'(e.mb[i]));
          checkOutput("match", i, 32'(am[i]), 32'(e.ma[i] | e.mb[i]));
          checkOutput("fill", i, 32'(afill[i]), 32'(e.fill[i]));
          checkOutput("history", i, 32'(ahist[i]), 32'(e.hist[i]));
          checkOutput("match_count", i, 32'(acnt[i]), 32'(e.cnt[i]));
        end
      end
    end
  end

  initial begin
    int k;
    $display("[TB] start");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    // Pattern 1101
    applyStimulus(0, 1, 1, 0); applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0); applyStimulus(0, 1, 1, 0);
    // Run of ones, 8 long
    applyStimulus(1, 0, 0, 0);
    repeat (8) applyStimulus(0, 1, 1, 0);
    // Enable gating
    applyStimulus(1, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 1, 0);
    repeat (5) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    // Saturation, then clear against a simultaneous hit
    applyStimulus(1, 0, 0, 0);
    repeat (10) applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 1, 0);
    // Reset mid-sequence
    applyStimulus(1, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    repeat (4) applyStimulus(0, 1, 1, 0);
    // Zero pattern must not fire on a partially filled history
    applyStimulus(1, 0, 0, 0);
    repeat (7) applyStimulus(0, 1, 0, 0);
    // Reset overrides a simultaneous clear and enable
    applyStimulus(1, 1, 1, 1);
    // Random traffic, biased toward ones so the 1111/1101 patterns occur often
    for (int n = 0; n < 400; n++)
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge clock);
      k++;
    end
    #2;
    checkOutput("drain", 0, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
